// File: rtl/hold_pkg.sv
// Shared definitions for the hold scheduler: FSM state encoding,
// grant-index width helper and default timing constants.
package hold_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int HOLD_TIME_DEF = 60;
    localparam int GAP_TIME_DEF  = 4;

    // Grant index width; at least one bit even for tiny requester counts.
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hold_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of pend searching upward
// from (last+1) mod N_REQ, with wrap-around.
module hold_sched_rr_pick
    import hold_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] pend,
    input  logic [IDW-1:0]   last,
    output logic             vld,
    output logic [IDW-1:0]   idx
);

    logic [IDW-1:0] j;

    // Scan from the farthest offset down so the nearest candidate wins.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        j   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            j = IDW'((int'(last) + i) % N_REQ);
            if (pend[j]) begin
                vld = 1'b1;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/hold_sched.sv
// Round-robin scheduler sharing one stretched pulse output between N_REQ
// single-cycle event sources; each grant holds HOLD_TIME cycles then gaps.
module hold_sched
    import hold_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int HOLD_TIME = HOLD_TIME_DEF,
    parameter  int GAP_TIME  = GAP_TIME_DEF,
    parameter  int CNT_W     = 16,
    localparam int IDW       = idw(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic [N_REQ-1:0] req_i,
    input  logic             clr_i,
    output logic             hold_o,
    output logic [IDW-1:0]   grant_id_o,
    output logic             busy_o,
    output logic [N_REQ-1:0] pend_o,
    output logic [N_REQ-1:0] done_o
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TIME > 0) ? GAP_TIME - 1 : 0);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N_REQ-1:0] pend, pend_n, done_n, grant_mask, done_q;
    logic [IDW-1:0]   gid, gid_n, rr_last, pick_idx;
    logic             seen, seen_n, pick_vld, hold_q, busy_q;

    // Until the first grant the search must start at index 0.
    assign rr_last = seen ? gid : IDW'(N_REQ - 1);

    hold_sched_rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .pend (pend),
        .last (rr_last),
        .vld  (pick_vld),
        .idx  (pick_idx)
    );

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        gid_n      = gid;
        seen_n     = seen;
        done_n     = '0;
        grant_mask = '0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_n              = ST_HOLD;
                    cnt_n                = '0;
                    gid_n                = pick_idx;
                    seen_n               = 1'b1;
                    grant_mask[pick_idx] = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_n     = (GAP_TIME > 0) ? ST_GAP : ST_IDLE;
                    cnt_n       = '0;
                    done_n[gid] = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
        // A request in the same cycle beats both clear and grant.
        pend_n = ((clr_i ? '0 : pend) & ~grant_mask) | req_i;
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            pend   <= '0;
            gid    <= '0;
            seen   <= 1'b0;
            hold_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pend   <= pend_n;
            gid    <= gid_n;
            seen   <= seen_n;
            hold_q <= (state_n == ST_HOLD);
            busy_q <= (state_n != ST_IDLE);
            done_q <= done_n;
        end
    end

    assign hold_o     = hold_q;
    assign grant_id_o = gid;
    assign busy_o     = busy_q;
    assign pend_o     = pend;
    assign done_o     = done_q;

endmodule

// File: tb/tb_hold_sched.sv
// Directed bench for hold_sched: a vector table for the basic traces plus
// hand-written sequences for re-request, zero gap, clear and reset corners.
module tb_hold_sched;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, clr_a = 1'b0, rst_b = 1'b1, clr_b = 1'b0;
    logic [3:0] req_a = '0, req_b = '0;
    logic       hold_a, busy_a, hold_b, busy_b;
    logic [1:0] gid_a, gid_b;
    logic [3:0] pend_a, done_a, pend_b, done_b;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    hold_sched #(.N_REQ(4), .HOLD_TIME(4), .GAP_TIME(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst_p(rst_a), .req_i(req_a), .clr_i(clr_a),
        .hold_o(hold_a), .grant_id_o(gid_a), .busy_o(busy_a),
        .pend_o(pend_a), .done_o(done_a)
    );

    hold_sched #(.N_REQ(4), .HOLD_TIME(4), .GAP_TIME(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst_p(rst_b), .req_i(req_b), .clr_i(clr_b),
        .hold_o(hold_b), .grant_id_o(gid_b), .busy_o(busy_b),
        .pend_o(pend_b), .done_o(done_b)
    );

    typedef struct {
        int         rep;
        logic       rst;
        logic [3:0] req;
        logic       clr;
        logic       hold;
        logic [1:0] gid;
        logic       busy;
        logic [3:0] pend;
        logic [3:0] done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int rep, input logic rst, input logic [3:0] req, input logic clr,
                       input logic hold, input logic [1:0] gid, input logic busy,
                       input logic [3:0] pend, input logic [3:0] done);
        vec_t v;
        v.rep = rep; v.rst = rst; v.req = req; v.clr = clr; v.hold = hold;
        v.gid = gid; v.busy = busy; v.pend = pend; v.done = done;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick_a(input logic [3:0] req, input logic clr, input logic rst);
        @(posedge clk);
        #1;
        req_a = req; clr_a = clr; rst_a = rst;
        @(negedge clk);
    endtask

    task automatic tick_b(input logic [3:0] req, input logic clr, input logic rst);
        @(posedge clk);
        #1;
        req_b = req; clr_b = clr; rst_b = rst;
        @(negedge clk);
    endtask

    initial begin
        int n, dcnt, hcnt, lcnt;
        // Single request to source 2.
        add(1, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0100, 4'b0000);
        add(4, 0, 4'b0000, 0, 1, 2, 1, 4'b0000, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 2, 1, 4'b0000, 4'b0100);
        add(1, 0, 4'b0000, 0, 0, 2, 1, 4'b0000, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 2, 0, 4'b0000, 4'b0000);
        // Simultaneous sources 0 and 3 from reset.
        add(1, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 4'b1001, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 0, 0, 4'b1001, 4'b0000);
        add(4, 0, 4'b0000, 0, 1, 0, 1, 4'b1000, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 0, 1, 4'b1000, 4'b0001);
        add(1, 0, 4'b0000, 0, 0, 0, 1, 4'b1000, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 0, 0, 4'b1000, 4'b0000);
        add(4, 0, 4'b0000, 0, 1, 3, 1, 4'b0000, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 3, 1, 4'b0000, 4'b1000);
        add(1, 0, 4'b0000, 0, 0, 3, 1, 4'b0000, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 3, 0, 4'b0000, 4'b0000);
        // Round robin: last grant 1, pend 0011 plus new request on 2 -> 2, 0, 1.
        add(1, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0010, 4'b0000);
        add(1, 0, 4'b0011, 0, 1, 1, 1, 4'b0000, 4'b0000);
        add(1, 0, 4'b0100, 0, 1, 1, 1, 4'b0011, 4'b0000);
        add(2, 0, 4'b0000, 0, 1, 1, 1, 4'b0111, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 1, 1, 4'b0111, 4'b0010);
        add(1, 0, 4'b0000, 0, 0, 1, 1, 4'b0111, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 1, 0, 4'b0111, 4'b0000);
        add(4, 0, 4'b0000, 0, 1, 2, 1, 4'b0011, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 2, 1, 4'b0011, 4'b0100);
        add(1, 0, 4'b0000, 0, 0, 2, 1, 4'b0011, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 2, 0, 4'b0011, 4'b0000);
        add(4, 0, 4'b0000, 0, 1, 0, 1, 4'b0010, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 0, 1, 4'b0010, 4'b0001);
        add(1, 0, 4'b0000, 0, 0, 0, 1, 4'b0010, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0010, 4'b0000);
        add(4, 0, 4'b0000, 0, 1, 1, 1, 4'b0000, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 1, 1, 4'b0000, 4'b0010);
        add(1, 0, 4'b0000, 0, 0, 1, 1, 4'b0000, 4'b0000);
        add(1, 0, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0000);

        n = 0;
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                tick_a((r == 0) ? vecs[i].req : 4'b0000, (r == 0) ? vecs[i].clr : 1'b0, vecs[i].rst);
                chk($sformatf("vec%0d hold", n), hold_a, vecs[i].hold);
                chk($sformatf("vec%0d gid", n),  gid_a,  vecs[i].gid);
                chk($sformatf("vec%0d busy", n), busy_a, vecs[i].busy);
                chk($sformatf("vec%0d pend", n), pend_a, vecs[i].pend);
                chk($sformatf("vec%0d done", n), done_a, vecs[i].done);
                n++;
            end
        end

        // Re-request of source 1 during its own hold.
        tick_a(4'b0000, 0, 1);
        dcnt = 0;
        for (int c = 0; c <= 20; c++) begin
            tick_a((c == 0 || c == 3) ? 4'b0010 : 4'b0000, 0, 0);
            if (done_a[1]) dcnt++;
            if (c == 4) chk("rereq pend", pend_a, 4'b0010);
            if (c == 9) begin
                chk("rereq hold2", hold_a, 1'b1);
                chk("rereq gid2", gid_a, 2'd1);
            end
            if (c == 13) chk("rereq done2", done_a, 4'b0010);
        end
        chk("rereq done count", dcnt, 2);

        // Zero gap: exactly one low cycle between back-to-back holds.
        tick_b(4'b0000, 0, 1);
        lcnt = 0;
        for (int c = 0; c <= 12; c++) begin
            tick_b((c == 0) ? 4'b0011 : 4'b0000, 0, 0);
            if (c >= 2 && c <= 10 && !hold_b) lcnt++;
            if (c == 6) begin
                chk("gap0 idle hold", hold_b, 1'b0);
                chk("gap0 idle busy", busy_b, 1'b0);
                chk("gap0 done0", done_b, 4'b0001);
            end
            if (c == 7) begin
                chk("gap0 hold2", hold_b, 1'b1);
                chk("gap0 gid2", gid_b, 2'd1);
            end
        end
        chk("gap0 low cycles", lcnt, 1);

        // Clear and request in the same cycle: the request survives.
        tick_b(4'b0000, 0, 1);
        for (int c = 0; c <= 8; c++) begin
            tick_b((c == 0) ? 4'b0011 : ((c == 2) ? 4'b0100 : 4'b0000), (c == 2), 0);
            if (c == 3) chk("clrreq pend", pend_b, 4'b0100);
            if (c == 7) chk("clrreq gid", gid_b, 2'd2);
        end

        // Clear during the first hold cancels the second request.
        tick_b(4'b0000, 0, 1);
        hcnt = 0;
        for (int c = 0; c <= 16; c++) begin
            tick_b((c == 0) ? 4'b0011 : 4'b0000, (c == 3), 0);
            if (c == 4) begin
                chk("clr pend", pend_b, 4'b0000);
                chk("clr keeps hold", hold_b, 1'b1);
            end
            if (c == 6) chk("clr done0", done_b, 4'b0001);
            if (c >= 6 && hold_b) hcnt++;
            if (c == 8) chk("clr busy", busy_b, 1'b0);
        end
        chk("clr no second hold", hcnt, 0);

        // Asynchronous reset while the counter sits at 2.
        tick_a(4'b0000, 0, 1);
        tick_a(4'b0001, 0, 0);
        tick_a(4'b0000, 0, 0);
        tick_a(4'b0010, 0, 0);
        tick_a(4'b0000, 0, 0);
        chk("rstmid pre hold", hold_a, 1'b1);
        tick_a(4'b0000, 0, 1);
        chk("rstmid hold", hold_a, 1'b0);
        chk("rstmid busy", busy_a, 1'b0);
        chk("rstmid pend", pend_a, 4'b0000);
        chk("rstmid done", done_a, 4'b0000);
        chk("rstmid gid", gid_a, 2'd0);
        dcnt = 0;
        hcnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick_a(4'b0000, 0, 0);
            if (done_a != 4'b0000) dcnt++;
            if (hold_a) hcnt++;
        end
        chk("rstmid no done after", dcnt, 0);
        chk("rstmid no hold after", hcnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
